// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one physical-memory line port between the instruction cache and
//   the data cache. One requester is granted at a time. Its command is latched,
//   so memory sees a stable request until pmem_resp. The response is routed
//   only to the granted cache. When both caches request together, the grant
//   alternates, so neither can starve the other.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   i_read          : icache line read request
//   i_address       : icache line address
//   i_rdata, i_resp : line data / completion returned to icache
//   d_read, d_write : dcache line read / writeback request
//   d_address       : dcache line address
//   d_wdata         : dcache writeback data
//   d_rdata, d_resp : line data / completion returned to dcache
//   pmem_*          : physical memory command (read/write/address/wdata) and
//                     its response (rdata/resp)
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] wdata;
    } cmd_t;

    state_t state, state_nxt;
    cmd_t   cmd, cmd_nxt;
    logic   last_d, last_d_nxt;   // 1: dcache held the most recent grant
    logic   i_pend, d_pend, grant_i, grant_d;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;
    // On a tie, the requester that did not hold the previous grant wins.
    assign grant_d = d_pend & (~i_pend | ~last_d);
    assign grant_i = i_pend & (~d_pend |  last_d);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
            cmd    <= '0;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
            cmd    <= cmd_nxt;
        end
    end

    // Next-state and command capture
    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        cmd_nxt    = cmd;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt     = D_BUSY;
                    last_d_nxt    = 1'b1;
                    // read+write together is illegal; it is handled as a write.
                    cmd_nxt.read  = ~d_write;
                    cmd_nxt.write = d_write;
                    cmd_nxt.addr  = d_address;
                    cmd_nxt.wdata = d_wdata;
                end else if (grant_i) begin
                    state_nxt     = I_BUSY;
                    last_d_nxt    = 1'b0;
                    cmd_nxt.read  = 1'b1;
                    cmd_nxt.write = 1'b0;
                    cmd_nxt.addr  = i_address;
                    cmd_nxt.wdata = '0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs. These are gated by state, so an asynchronous reset clears them
    // without waiting for a clock edge.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        if (state == I_BUSY || state == D_BUSY) begin
            pmem_read    = cmd.read;
            pmem_write   = cmd.write;
            pmem_address = cmd.addr;
            pmem_wdata   = cmd.wdata;
        end
        if (state == I_BUSY) i_resp = pmem_resp;
        if (state == D_BUSY) d_resp = pmem_resp;
    end

    // Read data is broadcast to both caches; each one qualifies it with its own resp.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule
